// File: rtl/mult4_seq_ctrl_if.sv
// Handshake and result bus of the 4x4 sequential shift-add multiplier.
// Optional macro: MULT4_DONE_PULSE_EN adds the one-cycle `done` completion pulse.
interface mult4_seq_ctrl_if;
    logic       start;
    logic [3:0] ABus;
    logic [3:0] BBus;
    logic       ready;
    logic [7:0] resultBus;
    logic [5:0] ps;
`ifdef MULT4_DONE_PULSE_EN
    logic       done;
`endif

`ifdef MULT4_DONE_PULSE_EN
    modport master (output start, ABus, BBus, input ready, resultBus, ps, done);
    modport slave  (input start, ABus, BBus, output ready, resultBus, ps, done);
`else
    modport master (output start, ABus, BBus, input ready, resultBus, ps);
    modport slave  (input start, ABus, BBus, output ready, resultBus, ps);
`endif
endinterface

// File: rtl/mult4_seq_ctrl.sv
// Sequential core of the 4x4 unsigned shift-add multiplier: operand/partial-product
// registers, one-hot step controller and start/ready handshake.
// Optional macro: MULT4_DONE_PULSE_EN adds a registered `done` pulse on return to IDLE.
module mult4_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    mult4_seq_ctrl_if.slave bus
);
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        STEP1 = 6'b000010,
        STEP2 = 6'b000100,
        LOAD  = 6'b001000,
        STEP4 = 6'b010000,
        STEP3 = 6'b100000
    } state_t;

    // Raw 6-bit register so illegal one-hot codes remain representable and recoverable.
    logic [5:0] ps_q;
    state_t     ps_d;
    logic [3:0] areg;
    logic [3:0] breg;
    logic [3:0] preg;
    logic       ready;
    logic       load_en;
    logic       step_en;
    logic [4:0] sum;

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= IDLE;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Next-state: IDLE waits for start, the rest advance unconditionally; illegal codes go to IDLE.
    always_comb begin
        ps_d = IDLE;
        case (ps_q)
            IDLE:    ps_d = bus.start ? LOAD : IDLE;
            LOAD:    ps_d = STEP1;
            STEP1:   ps_d = STEP2;
            STEP2:   ps_d = STEP3;
            STEP3:   ps_d = STEP4;
            STEP4:   ps_d = IDLE;
            default: ps_d = IDLE;
        endcase
    end

    // State decode into handshake and datapath enables; illegal codes enable nothing.
    always_comb begin
        ready   = 1'b0;
        load_en = 1'b0;
        step_en = 1'b0;
        case (ps_q)
            IDLE:                      ready   = 1'b1;
            LOAD:                      load_en = 1'b1;
            STEP1, STEP2, STEP3, STEP4: step_en = 1'b1;
            default: ;
        endcase
    end

    // Shift-add step: keep the carry as the top bit of the shifted partial product.
    assign sum = {1'b0, preg} + (areg[0] ? {1'b0, breg} : 5'd0);

    // Operand and partial-product registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            preg <= '0;
        end else if (load_en) begin
            areg <= bus.ABus;
            breg <= bus.BBus;
            preg <= '0;
        end else if (step_en) begin
            preg <= sum[4:1];
            areg <= {sum[0], areg[3:1]};
        end
    end

`ifdef MULT4_DONE_PULSE_EN
    logic done_q;

    // Completion pulse for the cycle that first re-enters IDLE after STEP4.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (ps_q == STEP4);
        end
    end

    assign bus.done = done_q;
`endif

    assign bus.ready     = ready;
    assign bus.resultBus = {preg, areg};
    assign bus.ps        = ps_q;
endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Self-checking bench for mult4_seq_ctrl: directed cases plus random operands
// checked against a plain a*b product and a 6-cycle run timeline.
module tb_mult4_seq_ctrl;
    logic clk;
    logic rst;
    int unsigned vectors;
    int unsigned miscompares;

    mult4_seq_ctrl_if bus ();

    mult4_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] PS_IDLE = 6'b000001;
    localparam logic [5:0] PS_LOAD = 6'b001000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_done(input string tag, input logic exp);
`ifdef MULT4_DONE_PULSE_EN
        chk(tag, {31'd0, bus.done}, {31'd0, exp});
`endif
    endtask

    // One complete run with a single-cycle start; checks ready/done over cycles 1..6
    // and the product a*b at cycle 6, then that the result holds in IDLE.
    task automatic run(input logic [3:0] a, input logic [3:0] b, input int unsigned idle_after);
        logic [7:0] prod;
        prod = 8'(a * b);
        bus.ABus  = a;
        bus.BBus  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("load_ps", {26'd0, bus.ps}, {26'd0, PS_LOAD});
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            chk("run_ready", {31'd0, bus.ready}, {31'd0, (k == 6)});
            chk_done("run_done", (k == 6));
        end
        chk("run_result", {24'd0, bus.resultBus}, {24'd0, prod});
        chk("run_ps_idle", {26'd0, bus.ps}, {26'd0, PS_IDLE});
        bus.ABus = ~a;
        bus.BBus = ~b;
        for (int k = 0; k < int'(idle_after); k++) begin
            tick();
            chk("hold_result", {24'd0, bus.resultBus}, {24'd0, prod});
            chk("hold_ready", {31'd0, bus.ready}, 32'd1);
            chk_done("hold_done", 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.ABus    = '0;
        bus.BBus    = '0;
        tick();
        tick();
        chk("rst_ps", {26'd0, bus.ps}, {26'd0, PS_IDLE});
        chk("rst_result", {24'd0, bus.resultBus}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk_done("rst_done", 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_ps", {26'd0, bus.ps}, {26'd0, PS_IDLE});

        // Directed operand pairs, including all-carry F x F and zero operand.
        run(4'hD, 4'hB, 2);
        run(4'hF, 4'hF, 1);
        run(4'h0, 4'h9, 1);
        run(4'h1, 4'hF, 1);

        // start pulses in cycles 3 and 5 are ignored: still one run.
        bus.ABus  = 4'h3;
        bus.BBus  = 4'h5;
        bus.start = 1'b1;
        tick();                       // cycle 1
        bus.start = 1'b0;
        tick();                       // cycle 2
        tick();                       // cycle 3
        bus.start = 1'b1;
        tick();                       // cycle 4
        bus.start = 1'b0;
        chk("ign_ready4", {31'd0, bus.ready}, 32'd0);
        tick();                       // cycle 5
        bus.start = 1'b1;
        chk("ign_ready5", {31'd0, bus.ready}, 32'd0);
        tick();                       // cycle 6
        bus.start = 1'b0;
        chk("ign_result", {24'd0, bus.resultBus}, 32'h0F);
        chk("ign_ps6", {26'd0, bus.ps}, {26'd0, PS_IDLE});
        chk_done("ign_done6", 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ign_stay", {26'd0, bus.ps}, {26'd0, PS_IDLE});
            chk_done("ign_nodone", 1'b0);
        end

        // Reset during STEP2 of 7 x 7 discards the run.
        bus.ABus  = 4'h7;
        bus.BBus  = 4'h7;
        bus.start = 1'b1;
        tick();                       // cycle 1 LOAD
        bus.start = 1'b0;
        tick();                       // cycle 2 STEP1
        tick();                       // cycle 3 STEP2
        rst = 1'b1;
        bus.start = 1'b1;             // rst wins over start
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("abort_ps", {26'd0, bus.ps}, {26'd0, PS_IDLE});
        chk("abort_result", {24'd0, bus.resultBus}, 32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk_done("abort_done", 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_stay", {26'd0, bus.ps}, {26'd0, PS_IDLE});
            chk_done("abort_nodone", 1'b0);
        end
        run(4'h7, 4'h7, 1);

        // start held high: three back-to-back runs, ready high one cycle in six.
        bus.ABus  = 4'h2;
        bus.BBus  = 4'h6;
        bus.start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("b2b_ready", {31'd0, bus.ready}, {31'd0, (k % 6 == 0)});
            chk_done("b2b_done", (k % 6 == 0));
            if (k % 6 == 0) begin
                chk("b2b_result", {24'd0, bus.resultBus}, 32'h0C);
            end
        end
        bus.start = 1'b0;
        tick();
        chk("b2b_stop", {26'd0, bus.ps}, {26'd0, PS_IDLE});

        // Random operand pairs.
        for (int n = 0; n < 24; n++) begin
            run(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), $urandom_range(2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
